// File: rtl/morse_keyer_pkg.sv
// Shared constants for the Morse keyer: word width, symbol codes and FSM state encoding.
package morse_keyer_pkg;

    localparam int MORSE_W = 10;

    localparam int         DOT_LEN   = 2;
    localparam logic [1:0] DOT_CODE  = 2'b10;
    localparam int         DASH_LEN  = 3;
    localparam logic [2:0] DASH_CODE = 3'b110;

    // Symbols pre-placed at the MSB end so they can be shifted right into position
    localparam logic [MORSE_W-1:0] DOT_WORD  = {DOT_CODE, 8'b0};
    localparam logic [MORSE_W-1:0] DASH_WORD = {DASH_CODE, 7'b0};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_EMIT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        PRESS = ST_PRESS,
        GAP   = ST_GAP,
        EMIT  = ST_EMIT
    } state_t;

endpackage

// File: rtl/morse_keyer_debounce.sv
// Two-flop synchroniser followed by a debouncer that only follows the input after
// DEBOUNCE_CYCLES consecutive differing samples, giving equal delay on both edges.
module morse_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            dout    <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            if (sync_p1 == dout) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                dout <= sync_p1;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/morse_keyer.sv
// Hand-key to Morse word converter: classifies debounced presses as dot or dash and
// emits the left-justified letter with a one-cycle load strobe after a letter gap.
module morse_keyer
    import morse_keyer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int UNIT_CYCLES     = 12500000,
    parameter int DASH_UNITS      = 2,
    parameter int GAP_UNITS       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key,
    output logic [9:0] morse,
    output logic       audioreg,
    output logic       overflow,
    output logic       busy
);

    localparam int DASH_T = DASH_UNITS * UNIT_CYCLES;
    localparam int GAP_T  = GAP_UNITS * UNIT_CYCLES;
    localparam int MAX_T  = (DASH_UNITS > GAP_UNITS ? DASH_UNITS : GAP_UNITS) * UNIT_CYCLES;
    localparam int CW     = $clog2(MAX_T + 1);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic [CW-1:0] lim);
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

    state_t               state;
    logic                 key_db;
    logic [MORSE_W-1:0]   sr;
    logic [3:0]           len;
    logic [CW-1:0]        cnt;
    logic                 drop;
    logic                 is_dash;
    logic [MORSE_W-1:0]   sym_word;
    logic [3:0]           sym_len;
    logic                 fits;

    morse_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk   (clk),
        .reset (reset),
        .din   (key),
        .dout  (key_db)
    );

    // cnt starts at 0 on the first high cycle, so a press of N cycles leaves cnt at N-1
    always_comb begin
        is_dash  = (cnt >= CW'(DASH_T - 1));
        sym_word = is_dash ? DASH_WORD : DOT_WORD;
        sym_len  = is_dash ? 4'(DASH_LEN) : 4'(DOT_LEN);
        fits     = ({1'b0, len} + {1'b0, sym_len}) <= 5'(MORSE_W);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sr       <= '0;
            len      <= '0;
            cnt      <= '0;
            drop     <= 1'b0;
            morse    <= '0;
            audioreg <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            audioreg <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_db) begin
                        state <= PRESS;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                PRESS: begin
                    if (!key_db) begin
                        if (fits) begin
                            sr  <= sr | (sym_word >> len);
                            len <= len + sym_len;
                        end else begin
                            drop <= 1'b1;
                        end
                        state <= GAP;
                        cnt   <= '0;
                    end else begin
                        cnt <= sat_inc(cnt, CW'(DASH_T));
                    end
                end
                GAP: begin
                    if (key_db) begin
                        state <= PRESS;
                        cnt   <= '0;
                    end else if (cnt == CW'(GAP_T - 1)) begin
                        // Outputs load on entry so the strobe and word coincide with EMIT
                        state    <= EMIT;
                        morse    <= sr;
                        overflow <= drop;
                        audioreg <= 1'b1;
                    end else begin
                        cnt <= sat_inc(cnt, CW'(MAX_T));
                    end
                end
                EMIT: begin
                    sr    <= '0;
                    len   <= '0;
                    cnt   <= '0;
                    drop  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
